// File: rtl/wfg_spi_arb_pkg.sv
// Shared types and constants for the wfg SPI channel arbiter.
package wfg_spi_arb_pkg;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_SYNC       = 3'd1,
    ST_WAIT_START = 3'd2,
    ST_WAIT_DONE  = 3'd3,
    ST_GAP        = 3'd4
  } arb_state_t;

  localparam int START_TIMEOUT_DEF = 15;
  localparam int CNT_W             = 8;

endpackage

// File: rtl/wfg_spi_arb_rr.sv
// Round-robin picker: first set valid bit at or above the pointer, wrapping.
module wfg_spi_arb_rr
  import wfg_spi_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] i_valid,
  input  logic [IDX_W-1:0]   i_ptr,
  output logic [IDX_W-1:0]   o_idx,
  output logic               o_any
);

  int w_j;

  // Walk downward so the lowest offset from the pointer is assigned last and wins.
  always_comb begin
    o_idx = i_ptr;
    o_any = 1'b0;
    w_j   = 0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      w_j = int'(i_ptr) + k;
      if (w_j >= NUM_REQ) w_j = w_j - NUM_REQ;
      if (i_valid[w_j[IDX_W-1:0]]) begin
        o_idx = w_j[IDX_W-1:0];
        o_any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/wfg_spi_arbiter.sv
// Shares one wfg SPI drive channel between NUM_REQ AXI-stream requesters,
// one word per transfer, with packet-level locking and an inter-transfer gap.
module wfg_spi_arbiter
  import wfg_spi_arb_pkg::*;
#(
  parameter int NUM_REQ         = 4,
  parameter int AXIS_DATA_WIDTH = 32,
  parameter int START_TIMEOUT   = START_TIMEOUT_DEF
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               en_i,
  input  logic [7:0]                         gap_cycles_i,
  input  logic [NUM_REQ-1:0]                 req_tvalid_i,
  input  logic [NUM_REQ-1:0]                 req_tlast_i,
  input  logic [NUM_REQ*AXIS_DATA_WIDTH-1:0] req_tdata_i,
  output logic [NUM_REQ-1:0]                 req_tready_o,
  output logic                               drv_sync_o,
  output logic                               drv_tvalid_o,
  output logic                               drv_tlast_o,
  output logic [AXIS_DATA_WIDTH-1:0]         drv_tdata_o,
  input  logic                               drv_tready_i,
  input  logic                               drv_active_i,
  output logic [NUM_REQ-1:0]                 cs_sel_o,
  output logic [$clog2(NUM_REQ)-1:0]         grant_idx_o,
  output logic                               busy_o,
  output logic                               err_timeout_o,
  input  logic                               err_clr_i
);

  localparam int                IDX_W       = $clog2(NUM_REQ);
  localparam logic [CNT_W-1:0]  TIMEOUT_VAL = CNT_W'(START_TIMEOUT);
  localparam logic [IDX_W-1:0]  LAST_IDX    = IDX_W'(NUM_REQ - 1);

  arb_state_t         r_state, w_state_nxt;
  logic [IDX_W-1:0]   r_grant, r_ptr, w_rr_idx, w_ptr_nxt;
  logic               r_lock, r_drop, r_err;
  logic [CNT_W-1:0]   r_cnt;
  logic               w_rr_any, w_start, w_timeout, w_gap_done;
  logic [NUM_REQ-1:0] w_onehot;

  wfg_spi_arb_rr #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_rr (
    .i_valid (req_tvalid_i),
    .i_ptr   (r_ptr),
    .o_idx   (w_rr_idx),
    .o_any   (w_rr_any)
  );

  assign w_start    = en_i && (r_lock ? req_tvalid_i[r_grant] : w_rr_any);
  assign w_timeout  = (r_state == ST_WAIT_START) && !drv_active_i && (r_cnt == TIMEOUT_VAL);
  // A gap of 0 still spends one cycle in GAP; otherwise GAP lasts gap_cycles_i cycles.
  assign w_gap_done = ({1'b0, r_cnt} + {{CNT_W{1'b0}}, 1'b1}) >= {1'b0, gap_cycles_i};
  assign w_onehot   = NUM_REQ'(1) << r_grant;
  assign w_ptr_nxt  = (r_grant == LAST_IDX) ? '0 : r_grant + 1'b1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:       if (w_start) w_state_nxt = ST_SYNC;
      ST_SYNC:       if (drv_tready_i) w_state_nxt = ST_WAIT_START;
      ST_WAIT_START: if (drv_active_i) w_state_nxt = ST_WAIT_DONE;
                     else if (w_timeout) w_state_nxt = ST_GAP;
      ST_WAIT_DONE:  if (!drv_active_i) w_state_nxt = ST_GAP;
      ST_GAP:        if (!en_i || w_gap_done) w_state_nxt = ST_IDLE;
      default:       w_state_nxt = ST_IDLE;
    endcase
  end

  // r_drop remembers an en_i drop seen mid-word so the lock is released once the word ends.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_grant <= '0;
      r_ptr   <= '0;
      r_lock  <= 1'b0;
      r_drop  <= 1'b0;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_drop <= 1'b0;
          if (!en_i) r_lock <= 1'b0;
          else if (!r_lock && w_rr_any) r_grant <= w_rr_idx;
        end
        ST_SYNC: begin
          if (!en_i) r_drop <= 1'b1;
          if (drv_tready_i) begin
            r_lock <= ~req_tlast_i[r_grant];
            r_cnt  <= '0;
          end
        end
        ST_WAIT_START: begin
          if (!en_i) r_drop <= 1'b1;
          if (w_timeout) begin
            r_lock <= 1'b0;
            r_cnt  <= '0;
          end else if (!drv_active_i) begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        ST_WAIT_DONE: begin
          if (!en_i) r_drop <= 1'b1;
          if (!drv_active_i) begin
            r_cnt <= '0;
            if (!en_i || r_drop) r_lock <= 1'b0;
          end
        end
        ST_GAP: begin
          r_drop <= 1'b0;
          if (!r_lock || !en_i) r_ptr <= w_ptr_nxt;
          if (!en_i) r_lock <= 1'b0;
          r_cnt <= r_cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)            r_err <= 1'b0;
    else if (err_clr_i) r_err <= 1'b0;
    else if (w_timeout) r_err <= 1'b1;
  end

  always_comb begin
    drv_sync_o   = 1'b0;
    drv_tvalid_o = 1'b0;
    drv_tlast_o  = 1'b0;
    drv_tdata_o  = '0;
    req_tready_o = '0;
    cs_sel_o     = '0;
    case (r_state)
      ST_SYNC: begin
        drv_sync_o   = 1'b1;
        drv_tvalid_o = 1'b1;
        drv_tlast_o  = req_tlast_i[r_grant];
        drv_tdata_o  = req_tdata_i[int'(r_grant)*AXIS_DATA_WIDTH +: AXIS_DATA_WIDTH];
        req_tready_o = drv_tready_i ? w_onehot : '0;
        cs_sel_o     = w_onehot;
      end
      ST_WAIT_START, ST_WAIT_DONE: cs_sel_o = w_onehot;
      ST_IDLE, ST_GAP:             cs_sel_o = r_lock ? w_onehot : '0;
      default: ;
    endcase
  end

  assign busy_o        = (r_state != ST_IDLE);
  assign grant_idx_o   = r_grant;
  assign err_timeout_o = r_err;

endmodule

// File: tb/tb_wfg_spi_arbiter.sv
// Directed bench for wfg_spi_arbiter with a hand-driven SPI driver model.
module tb_wfg_spi_arbiter;

  logic         clk = 1'b0;
  logic         rst;
  logic         en_i;
  logic [7:0]   gap_cycles_i;
  logic [3:0]   req_tvalid_i;
  logic [3:0]   req_tlast_i;
  logic [127:0] req_tdata_i;
  logic [3:0]   req_tready_o;
  logic         drv_sync_o, drv_tvalid_o, drv_tlast_o;
  logic [31:0]  drv_tdata_o;
  logic         drv_tready_i, drv_active_i;
  logic [3:0]   cs_sel_o;
  logic [1:0]   grant_idx_o;
  logic         busy_o, err_timeout_o, err_clr_i;

  int n_assert = 0;
  int n_fail   = 0;

  wfg_spi_arbiter dut (
    .clk           (clk),
    .rst           (rst),
    .en_i          (en_i),
    .gap_cycles_i  (gap_cycles_i),
    .req_tvalid_i  (req_tvalid_i),
    .req_tlast_i   (req_tlast_i),
    .req_tdata_i   (req_tdata_i),
    .req_tready_o  (req_tready_o),
    .drv_sync_o    (drv_sync_o),
    .drv_tvalid_o  (drv_tvalid_o),
    .drv_tlast_o   (drv_tlast_o),
    .drv_tdata_o   (drv_tdata_o),
    .drv_tready_i  (drv_tready_i),
    .drv_active_i  (drv_active_i),
    .cs_sel_o      (cs_sel_o),
    .grant_idx_o   (grant_idx_o),
    .busy_o        (busy_o),
    .err_timeout_o (err_timeout_o),
    .err_clr_i     (err_clr_i)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One word: SYNC, driver goes active, driver finishes, then gsteps cycles of GAP.
  task automatic xfer(input int g, input logic [31:0] d, input logic l,
                      input logic [3:0] csg, input int gsteps);
    logic [3:0] oh;
    oh = 4'b0001 << g;
    step();
    chk("sync", {31'b0, drv_sync_o}, 32'd1);
    chk("tvalid", {31'b0, drv_tvalid_o}, 32'd1);
    chk("grant", {30'b0, grant_idx_o}, g);
    chk("tdata", drv_tdata_o, d);
    chk("tlast", {31'b0, drv_tlast_o}, {31'b0, l});
    chk("rdy_sync", {28'b0, req_tready_o}, {28'b0, oh});
    chk("cs_sync", {28'b0, cs_sel_o}, {28'b0, oh});
    drv_active_i = 1'b1;
    step();
    chk("rdy_wait", {28'b0, req_tready_o}, 32'd0);
    chk("sync_wait", {31'b0, drv_sync_o}, 32'd0);
    step();
    drv_active_i = 1'b0;
    step();
    chk("busy_gap", {31'b0, busy_o}, 32'd1);
    chk("cs_gap", {28'b0, cs_sel_o}, {28'b0, csg});
    repeat (gsteps) step();
    chk("busy_idle", {31'b0, busy_o}, 32'd0);
    chk("cs_idle", {28'b0, cs_sel_o}, {28'b0, csg});
  endtask

  initial begin
    rst = 1'b1; en_i = 1'b0; gap_cycles_i = 8'd0; req_tvalid_i = '0; req_tlast_i = '0;
    req_tdata_i = '0; drv_tready_i = 1'b1; drv_active_i = 1'b0; err_clr_i = 1'b0;
    #12;
    chk("rst_flags", {28'b0, drv_sync_o, drv_tvalid_o, drv_tlast_o, err_timeout_o}, 32'd0);
    chk("rst_busy", {31'b0, busy_o}, 32'd0);
    chk("rst_cs", {28'b0, cs_sel_o}, 32'd0);
    chk("rst_grant", {30'b0, grant_idx_o}, 32'd0);
    chk("rst_rdy", {28'b0, req_tready_o}, 32'd0);
    chk("rst_tdata", drv_tdata_o, 32'd0);
    @(posedge clk); #2;
    rst = 1'b0; en_i = 1'b1; gap_cycles_i = 8'd2;

    // Single word from req0 with a 2-cycle gap
    req_tdata_i = {96'h0, 32'hA5A5_A5A5};
    req_tlast_i = 4'b0001; req_tvalid_i = 4'b0001;
    #1;
    chk("t1_nosync", {31'b0, drv_sync_o}, 32'd0);
    xfer(0, 32'hA5A5_A5A5, 1'b1, 4'b0000, 2);
    req_tvalid_i = '0;

    // Fresh pointer, all requesters valid with single-word packets
    rst = 1'b1; step(); rst = 1'b0;
    gap_cycles_i = 8'd0;
    req_tdata_i = {32'h3333_3333, 32'h2222_2222, 32'h1111_1111, 32'h0F0F_0F0F};
    req_tlast_i = 4'b1111; req_tvalid_i = 4'b1111;
    xfer(0, 32'h0F0F_0F0F, 1'b1, 4'b0000, 1);
    xfer(1, 32'h1111_1111, 1'b1, 4'b0000, 1);
    xfer(2, 32'h2222_2222, 1'b1, 4'b0000, 1);
    xfer(3, 32'h3333_3333, 1'b1, 4'b0000, 1);
    xfer(0, 32'h0F0F_0F0F, 1'b1, 4'b0000, 1);
    req_tvalid_i = '0;

    // Locked three-word packet from req1 while req2 waits
    req_tlast_i = 4'b0100; req_tvalid_i = 4'b0110;
    xfer(1, 32'h1111_1111, 1'b0, 4'b0010, 1);
    xfer(1, 32'h1111_1111, 1'b0, 4'b0010, 1);
    req_tlast_i = 4'b0110;
    xfer(1, 32'h1111_1111, 1'b1, 4'b0000, 1);
    xfer(2, 32'h2222_2222, 1'b1, 4'b0000, 1);
    req_tvalid_i = '0;

    // Start timeout: driver never goes active
    req_tlast_i = 4'b1000; req_tvalid_i = 4'b1000;
    step();
    chk("t4_grant", {30'b0, grant_idx_o}, 32'd3);
    req_tvalid_i = '0;
    step();
    repeat (10) step();
    chk("t4_err_early", {31'b0, err_timeout_o}, 32'd0);
    chk("t4_busy_wait", {31'b0, busy_o}, 32'd1);
    repeat (10) step();
    chk("t4_err_set", {31'b0, err_timeout_o}, 32'd1);
    chk("t4_idle", {31'b0, busy_o}, 32'd0);
    chk("t4_cs", {28'b0, cs_sel_o}, 32'd0);
    err_clr_i = 1'b1;
    step();
    err_clr_i = 1'b0;
    chk("t4_err_clr", {31'b0, err_timeout_o}, 32'd0);
    req_tlast_i = 4'b1111; req_tvalid_i = 4'b0001;
    xfer(0, 32'h0F0F_0F0F, 1'b1, 4'b0000, 1);
    req_tvalid_i = '0;

    // en_i dropped during WAIT_DONE of a locked packet
    req_tlast_i = 4'b0100; req_tvalid_i = 4'b0110;
    step();
    chk("t5_grant", {30'b0, grant_idx_o}, 32'd1);
    drv_active_i = 1'b1;
    step(); step();
    en_i = 1'b0;
    step();
    chk("t5_busy_done", {31'b0, busy_o}, 32'd1);
    chk("t5_cs_done", {28'b0, cs_sel_o}, 32'h2);
    drv_active_i = 1'b0;
    step();
    chk("t5_gap_busy", {31'b0, busy_o}, 32'd1);
    chk("t5_unlocked", {28'b0, cs_sel_o}, 32'd0);
    step();
    chk("t5_idle", {31'b0, busy_o}, 32'd0);
    repeat (3) step();
    chk("t5_nosync", {31'b0, drv_sync_o}, 32'd0);
    chk("t5_stay_idle", {31'b0, busy_o}, 32'd0);
    en_i = 1'b1;
    xfer(2, 32'h2222_2222, 1'b1, 4'b0000, 1);
    req_tvalid_i = '0;

    // Asynchronous reset in WAIT_DONE
    req_tlast_i = 4'b1111; req_tvalid_i = 4'b0001;
    step();
    chk("t6_grant", {30'b0, grant_idx_o}, 32'd0);
    req_tvalid_i = '0;
    drv_active_i = 1'b1;
    step(); step();
    chk("t6_busy", {31'b0, busy_o}, 32'd1);
    chk("t6_cs", {28'b0, cs_sel_o}, 32'h1);
    rst = 1'b1;
    #1;
    chk("t6_rst_busy", {31'b0, busy_o}, 32'd0);
    chk("t6_rst_cs", {28'b0, cs_sel_o}, 32'd0);
    chk("t6_rst_flags", {29'b0, drv_sync_o, drv_tvalid_o, err_timeout_o}, 32'd0);
    step();
    rst = 1'b0; drv_active_i = 1'b0;
    req_tlast_i = 4'b1000; req_tvalid_i = 4'b1000;
    xfer(3, 32'h3333_3333, 1'b1, 4'b0000, 1);
    req_tvalid_i = '0;
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/wfg_spi_arbiter.md
Name: wfg_spi_arbiter

Overview:
- Sequences and shares one wfg SPI drive channel between NUM_REQ AXI-stream requesters.
- Arbitrates round-robin at packet boundaries and presents one word per transfer to the SPI driver.
- Issues the driver's sync pulse, tracks transfer start/end via the driver's active flag, enforces a programmable inter-transfer gap, and selects a per-requester slave line.
- Sits between the pattern/stream sources and the SPI drive block.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- AXIS_DATA_WIDTH, 32, stream data width.
- START_TIMEOUT, 15, cycles to wait for drv_active_i to rise after sync before flagging an error.

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous active-high reset.
- en_i  input  1  arbiter enable.
- gap_cycles_i  input  8  idle cycles inserted after each transfer.
- req_tvalid_i  input  NUM_REQ  per-requester valid.
- req_tlast_i  input  NUM_REQ  per-requester last (end of packet).
- req_tdata_i  input  NUM_REQ*AXIS_DATA_WIDTH  packed data; requester k occupies bits [k*W +: W].
- req_tready_o  output  NUM_REQ  per-requester ready.
- drv_sync_o  output  1  start pulse to the SPI driver.
- drv_tvalid_o  output  1  valid to the driver.
- drv_tlast_o  output  1  last to the driver.
- drv_tdata_o  output  AXIS_DATA_WIDTH  data to the driver.
- drv_tready_i  input  1  driver ready.
- drv_active_i  input  1  driver transfer in progress (internal chip-select active).
- cs_sel_o  output  NUM_REQ  one-hot slave select of the granted requester.
- grant_idx_o  output  $clog2(NUM_REQ)  current/last grant index.
- busy_o  output  1  high in any state except IDLE.
- err_timeout_o  output  1  sticky start-timeout flag.
- err_clr_i  input  1  clears err_timeout_o.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-high.
- Reset values: all outputs 0; state IDLE; round-robin pointer 0; lock 0; counters 0.
- States: IDLE, SYNC, WAIT_START, WAIT_DONE, GAP.
- IDLE, unlocked:
  - When en_i=1 and any req_tvalid_i is set, pick the first valid requester searching upward from the pointer (wrapping at NUM_REQ).
  - Register the grant and go to SYNC. Latency: valid at cycle t gives drv_sync_o at t+1.
- IDLE, locked: go to SYNC only when req_tvalid_i[grant]=1. Other requesters are ignored.
- SYNC:
  - Assert drv_sync_o=1 and drv_tvalid_o=1.
  - drv_tdata_o/drv_tlast_o are the granted requester's signals; req_tready_o[grant]=drv_tready_i; all other readies are 0.
  - If drv_tready_i=1: capture tlast into the lock (lock = ~tlast) and go to WAIT_START. Otherwise stay in SYNC and re-pulse.
  - drv_* outputs are 0 outside SYNC.
- WAIT_START:
  - Clear the timeout counter on entry.
  - If drv_active_i=1, go to WAIT_DONE.
  - If the counter reaches START_TIMEOUT, set err_timeout_o, clear the lock, and go to GAP.
- WAIT_DONE: when drv_active_i=0, go to GAP.
- GAP:
  - Count gap_cycles_i cycles, then go to IDLE. gap_cycles_i=0 means go to IDLE on the next cycle.
  - If the lock is 0, the pointer becomes (grant+1) mod NUM_REQ.
- cs_sel_o:
  - onehot(grant) from SYNC through WAIT_DONE, and in GAP/IDLE while locked.
  - 0 otherwise.
- en_i deassert:
  - In IDLE or GAP: clear the lock and go to IDLE immediately.
  - In SYNC, WAIT_START or WAIT_DONE: finish the current word, then clear the lock.
- err_timeout_o: err_clr_i has priority over setting in the same cycle.
- Reset mid-transfer: immediate return to reset values; the driver is left to finish its frame.

Decomposition:
- Package wfg_spi_arb_pkg holds:
  - the state enum;
  - the default START_TIMEOUT;
  - the counter width constant (8).
- Sub-module wfg_spi_arb_rr: parameterised round-robin picker taking valid and pointer, returning the grant index and an any-valid flag.

Test Plan:
1. req0 valid (tlast=1, data 0xA5A5A5A5), gap=2, drv_active high 3 cycles after sync → drv_sync_o one cycle at t+1, drv_tdata_o=0xA5A5A5A5, cs_sel_o=0001, IDLE reached 2 cycles after active falls.
2. req0..req3 all continuously valid with tlast=1 → grants in order 0,1,2,3,0; each requester sees exactly one tready per word.
3. req1 sends 3 words with tlast only on the third, req2 valid throughout → words 1,1,1 precede any req2 grant; cs_sel_o stays 0010 across the gaps.
4. drv_active_i held 0 after sync → err_timeout_o=1 after 15 cycles and stays set; err_clr_i pulse clears it; the next request proceeds normally.
5. en_i dropped during WAIT_DONE of a locked burst → current word completes, lock released, no further sync issued; en_i re-raised resumes round-robin from grant+1.
6. rst asserted in WAIT_DONE → all outputs 0 asynchronously; after release, req3 valid → grant 3 on the first arbitration.
